code_packer: RTL
================

Name: code_packer

Overview:
- Downstream neighbour of the compressed-word concatenator in the compression datapath.
- Accepts one variable-length compressed code per handshake, right-aligned with its type code in the LSBs. Derives the code's bit length from the 3-bit pattern code.
- Packs codes LSB-first into a continuous bitstream and emits fixed OUT_WIDTH-bit words over a valid/ready interface.
- A flush request drains the residue as a zero-padded, length-tagged final word.

Parameters:
- TOTAL_BITS, 34, width of the incoming compressed word (longest code).
- OUT_WIDTH, 64, width of each packed output word; must be ≥ TOTAL_BITS.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_valid  input  1  compressed code present.
- o_ready  output  1  packer can accept a code this cycle.
- i_code  input  3  pattern code: 000 zzzz, 001 mmmm, 010 zzzx, 011 mmmx, 100 mmxx, 101 xxxx.
- i_compressed_word  input  TOTAL_BITS  right-aligned code bits; bits above the code length are ignored.
- i_flush  input  1  single-cycle request to drain the stream.
- o_valid  output  1  o_data holds a packed word.
- i_ready  input  1  downstream accepts o_data.
- o_data  output  OUT_WIDTH  packed word; the stream's first bit is at bit 0.
- o_bits  output  $clog2(OUT_WIDTH)+1  number of meaningful bits in o_data; OUT_WIDTH except on a partial final word.
- o_last  output  1  o_data is the final word of a flush.
- o_flush_done  output  1  one-cycle pulse when a flush has fully completed.
- o_code_err  output  1  one-cycle pulse when an accepted code is 110 or 111.

Behaviour:
- Length map: 000→2, 001→6, 010→12, 011→16, 100→24, 101→34. 110/111→0: the code is accepted, nothing is packed, and o_code_err pulses the cycle after acceptance.
- Accumulator width is OUT_WIDTH+TOTAL_BITS. The fill count runs 0..OUT_WIDTH+TOTAL_BITS-1.
- On an accepted code, the masked code bits are ORed into the accumulator at position fill, and fill += len.
- Input handshake: o_ready = (state==PACK) && (fill < OUT_WIDTH). A transfer occurs when i_valid && o_ready.
- Word extraction happens when fill ≥ OUT_WIDTH and (!o_valid || i_ready):
  - o_data ← acc[OUT_WIDTH-1:0], o_bits ← OUT_WIDTH.
  - acc >>= OUT_WIDTH, fill -= OUT_WIDTH.
- Input acceptance and extraction are mutually exclusive by the fill condition. Full throughput is one code per cycle, except one stall cycle whenever fill crosses OUT_WIDTH.
- o_valid stays high and o_data/o_bits/o_last stay stable until i_ready. When extraction replaces a consumed word, back-to-back output occurs with no bubble.
- FSM:
  - PACK: normal operation. If i_flush is seen, go to FLUSH. A code accepted in the same cycle as i_flush is included in the flush.
  - FLUSH: o_ready=0.
    - Extract full words as above. An extracted word whose remaining fill becomes 0 carries o_last=1.
    - When 0 < fill < OUT_WIDTH and the output is free: emit acc[OUT_WIDTH-1:0] with zero padding, o_bits=fill, o_last=1; clear acc and set fill=0.
    - Once fill==0, go to DRAIN.
  - DRAIN: wait until !o_valid or the last word is accepted. Then pulse o_flush_done for one cycle and return to PACK.
  - A flush with fill==0 emits no word; o_flush_done pulses 2 cycles after i_flush.
- i_flush is ignored outside PACK.
- Reset, including mid-operation, takes effect immediately:
  - acc=0, fill=0, state=PACK.
  - o_valid=0, o_data=0, o_bits=0, o_last=0, o_flush_done=0, o_code_err=0.
  - o_ready=1 once reset is released.
  - Any residue is discarded.

Test Plan:
- 32 × code 000 (word 0) back-to-back, i_ready=1 → exactly one output, o_data=64'h0, o_bits=64, o_last=0; fill returns to 0.
- Two code 101 with word {32'hDEADBEEF,2'b01} (0x37AB6FBBD), then i_flush, i_ready=1:
  - First output o_data=64'hEADBEEF7_7AB6FBBD, o_bits=64, o_last=0.
  - Second output o_data=64'hD, o_bits=4, o_last=1.
  - o_flush_done pulses once afterwards.
- Code 001 word 0x16, then code 010 word 0xA57, then i_flush → o_data=64'h295D6, o_bits=18, o_last=1, then o_flush_done.
- Backpressure: i_ready=0, five code 101 inputs offered:
  - o_valid rises and o_data holds constant.
  - o_ready goes low once fill ≥ 64 with the output occupied.
  - Releasing i_ready resumes with no lost or duplicated bits; compare against a bit-serial reference model.
- Code 110 accepted between two code 000 → o_code_err pulses once; a flush yields o_bits=4, o_data=0.
- Assert i_rst after three code 101 inputs while o_valid=1 → all outputs 0 the same cycle; post-reset flush gives only o_flush_done with no word.

Source files
------------

// File: rtl/code_packer.sv
// -----------------------------------------------------------------------------
// code_packer
//
// Packs variable-length compressed codes LSB-first into a continuous bitstream
// and emits fixed OUT_WIDTH-bit words. Each incoming code is right-aligned in
// i_compressed_word; its bit length comes from the 3-bit pattern code. A flush
// request drains whatever residue remains as a zero-padded final word tagged
// with its meaningful bit count.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_valid / o_ready     input handshake for one compressed code
//   i_code                pattern code (selects code length)
//   i_compressed_word     right-aligned code bits
//   i_flush               single-cycle drain request (honoured in PACK only)
//   o_valid / i_ready     output handshake for one packed word
//   o_data                packed word, first stream bit at bit 0
//   o_bits                meaningful bits in o_data
//   o_last                o_data is the final word of a flush
//   o_flush_done          one-cycle pulse once a flush has completed
//   o_code_err            one-cycle pulse after accepting code 110/111
// -----------------------------------------------------------------------------
module code_packer #(
  parameter int TOTAL_BITS = 34,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2:0]                 i_code,
  input  logic [TOTAL_BITS-1:0]      i_compressed_word,
  input  logic                       i_flush,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [OUT_WIDTH-1:0]       o_data,
  output logic [$clog2(OUT_WIDTH):0] o_bits,
  output logic                       o_last,
  output logic                       o_flush_done,
  output logic                       o_code_err
);

  localparam int ACC_W  = OUT_WIDTH + TOTAL_BITS;
  localparam int FILL_W = $clog2(ACC_W);
  localparam int BITS_W = $clog2(OUT_WIDTH) + 1;
  localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_WIDTH);

  typedef enum logic [1:0] {
    PACK  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic                valid_q, valid_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic [BITS_W-1:0]   bits_q, bits_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [FILL_W-1:0]   codeLen;
  logic [ACC_W-1:0]    codeMask;
  logic [ACC_W-1:0]    codeBits;
  logic [ACC_W-1:0]    codeShifted;
  logic                accept;
  logic                outFree;

  // Bit length of each pattern code; the two reserved codes pack nothing.
  function automatic logic [FILL_W-1:0] lenOf(input logic [2:0] code);
    logic [FILL_W-1:0] len;
    case (code)
      3'b000:  len = FILL_W'(2);
      3'b001:  len = FILL_W'(6);
      3'b010:  len = FILL_W'(12);
      3'b011:  len = FILL_W'(16);
      3'b100:  len = FILL_W'(24);
      3'b101:  len = FILL_W'(34);
      default: len = '0;
    endcase
    return len;
  endfunction

  // Bits above the code length are don't-care on the input, so they are
  // masked off before being merged at the current fill position.
  assign codeLen     = lenOf(i_code);
  assign codeMask    = ~({ACC_W{1'b1}} << codeLen);
  assign codeBits    = {{OUT_WIDTH{1'b0}}, i_compressed_word} & codeMask;
  assign codeShifted = codeBits << fill_q;

  // Accepting only while fill < OUT_WIDTH keeps the merge inside the
  // accumulator and makes acceptance and extraction mutually exclusive.
  assign o_ready = (state_q == PACK) && (fill_q < OUT_FILL);
  assign accept  = i_valid && o_ready;
  assign outFree = !valid_q || i_ready;

  // Next-state logic: stream accumulation, word extraction and flush sequencing.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    data_d  = data_q;
    bits_d  = bits_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      PACK: begin
        if (accept) begin
          acc_d  = acc_q | codeShifted;
          fill_d = fill_q + codeLen;
          err_d  = (i_code[2:1] == 2'b11);
        end else if ((fill_q >= OUT_FILL) && outFree) begin
          valid_d = 1'b1;
          data_d  = acc_q[OUT_WIDTH-1:0];
          bits_d  = BITS_W'(OUT_WIDTH);
          last_d  = 1'b0;
          acc_d   = acc_q >> OUT_WIDTH;
          fill_d  = fill_q - OUT_FILL;
        end
        if (i_flush) begin
          state_d = FLUSH;
        end
      end

      FLUSH: begin
        if (fill_q >= OUT_FILL) begin
          if (outFree) begin
            valid_d = 1'b1;
            data_d  = acc_q[OUT_WIDTH-1:0];
            bits_d  = BITS_W'(OUT_WIDTH);
            last_d  = (fill_q == OUT_FILL);
            acc_d   = acc_q >> OUT_WIDTH;
            fill_d  = fill_q - OUT_FILL;
          end
        end else if (fill_q != '0) begin
          // Bits above fill are always zero, so the residue is already padded.
          if (outFree) begin
            valid_d = 1'b1;
            data_d  = acc_q[OUT_WIDTH-1:0];
            bits_d  = BITS_W'(fill_q);
            last_d  = 1'b1;
            acc_d   = '0;
            fill_d  = '0;
          end
        end else begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (outFree) begin
          done_d  = 1'b1;
          state_d = PACK;
        end
      end

      default: begin
        state_d = PACK;
      end
    endcase
  end

  // State and output registers; reset discards any residue immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= PACK;
      acc_q   <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      bits_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      bits_q  <= bits_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_valid      = valid_q;
  assign o_data       = data_q;
  assign o_bits       = bits_q;
  assign o_last       = last_q;
  assign o_flush_done = done_q;
  assign o_code_err   = err_q;

endmodule
